gpia_port_in: RTL
=================

// Module: gpia_port_in
// PURPOSE
//  W-bit GPIA input port: per-bit DDR readback mux, metastability sync and edge-event capture with IRQ.
//  Sits between external pins and PE I/O space; one instance per GPIA port.
//  Read data is registered and zero when not acknowledged, so several ports may be OR-ed onto one bus.
// PARAMETERS
//  W           8   port width in bits (1..32)
//  SYNC_STAGES 2   input synchroniser depth (>=2)
//  DB_CYCLES   4   debounce stable-cycle count (1..255); used only with GPIA_IN_DEBOUNCE_EN
// PORTS
//  clk_i    in   1  sole clock, all state on rising edge
//  reset_i  in   1  asynchronous reset, active-high
//  inp_i    in   W  external pin levels (asynchronous)
//  out_i    in   W  current output-latch value (from output port)
//  ddr_i    in   W  direction per bit: 1=output, 0=input
//  stb_i    in   1  bus cycle strobe, one access per cycle sampled
//  we_i     in   1  1=write, 0=read (qualified by stb_i)
//  sel_i    in   2  register: 0 DATA(RO) 1 EVT(W1C) 2 RISE_EN(RW) 3 FALL_EN(RW)
//  dat_i    in   W  write data
//  q_o      out  W  registered read data; 0 unless ack_o
//  ack_o    out  1  cycle acknowledge
//  irq_o    out  1  registered OR of EVT
// BEHAVIOUR
//  - Reset: q_o=0, ack_o=0, irq_o=0, EVT=0, RISE_EN=0, FALL_EN=0, sync/filter flops=0.
//  - Sync: inp_i passes SYNC_STAGES flops; s = last stage. Filtered value f = s (no debounce).
//  - DATA bit i = ddr_i[i] ? out_i[i] : f[i]; out_i side is combinational at the sampling edge.
//  - Access: stb_i sampled high at edge N -> ack_o=1 and q_o valid during cycle N..N+1; zero-latency
//    pipelining: stb_i held high acks every cycle. stb_i low -> ack_o=0, q_o=0 next cycle.
//  - Read: q_o = selected register value at edge N. Write: q_o=0; sel 0 write ignored but acked.
//  - EVT[i] sets at the edge where f[i] changes, if ddr_i[i]=0 and (rising&RISE_EN[i] | falling&FALL_EN[i]).
//  - EVT write: bits with dat_i=1 clear; set and clear same bit same edge -> set wins (no lost event).
//  - Output-direction bits never raise events; enabling an edge later never produces a spurious event
//    (edge compare uses previous f, always tracking).
//  - irq_o = registered |EVT (one cycle after EVT changes).
//  - Latency: inp_i stable before edge E -> s updates at edge E+SYNC_STAGES-1; DATA read sampled at
//    edge E+SYNC_STAGES returns new value; EVT set at edge E+SYNC_STAGES-1, irq_o at E+SYNC_STAGES.
//  - reset_i mid-access: ack_o/q_o drop immediately; pending access discarded.
// CONFIGURATION
//  GPIA_IN_DEBOUNCE_EN defined: per-bit 8-bit counter; f[i] takes s[i] only after s[i] differs from
//    f[i] for DB_CYCLES consecutive edges; any return to f[i] restarts count. Adds DB_CYCLES latency.
//  Undefined: f = s, no counters, DB_CYCLES ignored.
// STRUCTURE
//  gpia_pkg: GPIA_SEL_DATA/EVT/RISE_EN/FALL_EN sel encodings, GPIA_SYNC_MIN=2.
//  Sub-module gpia_in_bit: one bit of sync + optional debounce + edge detect (rise/fall pulses);
//    instantiated W times via generate. Register file, bus mux and irq in gpia_port_in.
// TESTING (W=8, SYNC_STAGES=2, DB_CYCLES=4)
//  1 Reset, stb_i=0, toggle inp_i/out_i -> q_o=0, ack_o=0, irq_o=0 throughout.
//  2 ddr=0x0F, out=0xA5, inp=0x3C settled; read DATA -> q_o=0x35, ack_o=1 one cycle after stb.
//  3 inp 0x00->0x01 before edge E; DATA reads at E+1 -> 0x00, at E+2 -> 0x01.
//  4 RISE_EN=0x01, inp[0] 0->1 -> EVT=0x01, irq_o=1; write EVT 0x01 -> EVT=0, irq_o=0 next cycle;
//    repeat with clear coinciding with new edge -> EVT stays 0x01.
//  5 ddr[0]=1, RISE_EN=FALL_EN=0xFF, toggle inp[0] -> EVT=0x00; write DATA 0xFF -> DATA unchanged.
//  6 Debounce build: 3-cycle glitch on inp[1] -> DATA bit1 unchanged, no event; 6-cycle hold -> changes.

Source files
------------

// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA input port: register select encodings and sync depth limits.
package gpia_pkg;

   typedef enum logic [1:0] {
      GPIA_SEL_DATA    = 2'd0,
      GPIA_SEL_EVT     = 2'd1,
      GPIA_SEL_RISE_EN = 2'd2,
      GPIA_SEL_FALL_EN = 2'd3
   } gpia_sel_e;

   localparam int unsigned GPIA_SYNC_MIN = 2;

   // A synchroniser shallower than two flops gives no metastability protection.
   function automatic int unsigned gpia_sync_depth(input int unsigned req);
      return (req < GPIA_SYNC_MIN) ? GPIA_SYNC_MIN : req;
   endfunction

endpackage

// File: rtl/gpia_in_bit.sv
// One GPIA input bit: synchroniser, optional debounce filter (GPIA_IN_DEBOUNCE_EN) and edge detect.
// rise_o/fall_o flag that the filtered value f_o changes at the coming clock edge.
module gpia_in_bit
   import gpia_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_CYCLES   = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic inp_i,
   output logic f_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned Stages = gpia_sync_depth(SYNC_STAGES);

   logic [Stages-1:0] sync_q, sync_d;
   logic              s_q;
   logic              f_q, f_d;

   always_comb sync_d = {sync_q[Stages-2:0], inp_i};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign s_q = sync_q[Stages-1];

`ifdef GPIA_IN_DEBOUNCE_EN
   localparam logic [7:0] DbLast = 8'(DB_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   // Any edge where s agrees with f restarts the stability count.
   always_comb begin
      f_d   = f_q;
      cnt_d = '0;
      if (s_q != f_q) begin
         if (cnt_q == DbLast) begin
            f_d = s_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         f_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         f_q   <= f_d;
         cnt_q <= cnt_d;
      end
   end
`else
   logic [7:0] unused_db;

   assign unused_db = 8'(DB_CYCLES);
   assign f_q       = s_q;
   assign f_d       = sync_q[Stages-2];
`endif

   assign f_o    = f_q;
   assign rise_o = f_d & ~f_q;
   assign fall_o = ~f_d & f_q;

endmodule

// File: rtl/gpia_port_in.sv
// GPIA input port: per-bit sync/edge cells, DATA/EVT/RISE_EN/FALL_EN registers, bus and irq.
// Optional debounce filtering is enabled by defining GPIA_IN_DEBOUNCE_EN.
module gpia_port_in
   import gpia_pkg::*;
#(
   parameter int unsigned W           = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_CYCLES   = 4
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [W-1:0] inp_i,
   input  logic [W-1:0] out_i,
   input  logic [W-1:0] ddr_i,
   input  logic         stb_i,
   input  logic         we_i,
   input  logic [1:0]   sel_i,
   input  logic [W-1:0] dat_i,
   output logic [W-1:0] q_o,
   output logic         ack_o,
   output logic         irq_o
);

   logic [W-1:0] f, rise, fall;
   logic [W-1:0] data;
   logic [W-1:0] evt_q, evt_d;
   logic [W-1:0] rise_en_q, rise_en_d;
   logic [W-1:0] fall_en_q, fall_en_d;
   logic [W-1:0] q_q, q_d;
   logic         ack_q, ack_d;
   logic         irq_q, irq_d;
   logic [W-1:0] rd_val, evt_set, evt_clr;
   logic         wr;
   gpia_sel_e    sel;

   for (genvar i = 0; i < W; i++) begin : g_bit
      gpia_in_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_bit (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .inp_i   (inp_i[i]),
         .f_o     (f[i]),
         .rise_o  (rise[i]),
         .fall_o  (fall[i])
      );
   end

   assign sel  = gpia_sel_e'(sel_i);
   assign wr   = stb_i & we_i;
   assign data = (ddr_i & out_i) | (~ddr_i & f);

   always_comb begin
      rd_val = '0;
      unique case (sel)
         GPIA_SEL_DATA:    rd_val = data;
         GPIA_SEL_EVT:     rd_val = evt_q;
         GPIA_SEL_RISE_EN: rd_val = rise_en_q;
         GPIA_SEL_FALL_EN: rd_val = fall_en_q;
         default:          rd_val = '0;
      endcase
   end

   // Set is OR-ed in after the clear so an edge coinciding with a W1C is never lost.
   always_comb begin
      evt_set   = ~ddr_i & ((rise & rise_en_q) | (fall & fall_en_q));
      evt_clr   = (wr && sel == GPIA_SEL_EVT) ? dat_i : '0;
      evt_d     = (evt_q & ~evt_clr) | evt_set;
      rise_en_d = (wr && sel == GPIA_SEL_RISE_EN) ? dat_i : rise_en_q;
      fall_en_d = (wr && sel == GPIA_SEL_FALL_EN) ? dat_i : fall_en_q;
      q_d       = (stb_i && !we_i) ? rd_val : '0;
      ack_d     = stb_i;
      irq_d     = |evt_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         evt_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         q_q       <= '0;
         ack_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         evt_q     <= evt_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         q_q       <= q_d;
         ack_q     <= ack_d;
         irq_q     <= irq_d;
      end
   end

   assign q_o   = q_q;
   assign ack_o = ack_q;
   assign irq_o = irq_q;

endmodule
